// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: register addresses, duty type
// and the bit positions of the optional BLINK register fields.
package led_pwm_pkg;

  localparam logic [2:0] LED_ADDR_CTRL     = 3'd0;
  localparam logic [2:0] LED_ADDR_DUTY0    = 3'd1;
  localparam logic [2:0] LED_ADDR_DUTY1    = 3'd2;
  localparam logic [2:0] LED_ADDR_PRESCALE = 3'd3;
  localparam logic [2:0] LED_ADDR_BLINK    = 3'd4;

  typedef logic [7:0] led_duty_t;

  localparam int LED_BLINK_MASK_LSB   = 0;
  localparam int LED_BLINK_PERIOD_LSB = 16;
  localparam int LED_BLINK_PERIOD_MSB = 23;

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler and PWM counter; period_end marks the last tick of a PWM period.
module led_pwm_timebase #(
  parameter int PRESCALE_BITS = 16,
  parameter int PWM_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic                     clear,
  output logic [PWM_BITS-1:0]      pwm,
  output logic                     period_end
);

  logic [PRESCALE_BITS-1:0] pre_reg;
  logic [PWM_BITS-1:0]      pwm_reg;
  logic                     tick;

  assign tick       = (pre_reg == prescale);
  assign period_end = tick && (pwm_reg == '1);
  assign pwm        = pwm_reg;

  // A prescale rewrite restarts the prescaler so a smaller compare value can
  // never be skipped past; the PWM counter keeps its phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_reg <= '0;
      pwm_reg <= '0;
    end else begin
      if (clear || tick) pre_reg <= '0;
      else               pre_reg <= pre_reg + 1'b1;
      if (tick)          pwm_reg <= pwm_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_interface.sv
// Memory-mapped LED PWM controller with double-buffered duties.
// Optional blink support is compiled in when LED_PWM_BLINK_EN is defined.
module led_pwm_interface
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS      = 4,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                write_req,
  input  logic [2:0]          addr,
  input  logic [31:0]         write_data,
  input  logic [3:0]          byte_enable,
  input  logic                read_req,
  output logic [31:0]         read_data,
  output logic                read_data_valid,
  output logic [NUM_LEDS-1:0] leds
);

  logic [NUM_LEDS-1:0]      en_reg;
  led_duty_t                duty_reg   [NUM_LEDS];
  led_duty_t                active_reg [NUM_LEDS];
  logic [PRESCALE_BITS-1:0] prescale_reg;
  logic [15:0]              prescale_next;
  logic [PWM_BITS-1:0]      pwm;
  logic                     period_end;
  logic                     prescale_wr;
  logic [NUM_LEDS-1:0]      duty_we;
  led_duty_t                duty_wdata [NUM_LEDS];
  logic [NUM_LEDS-1:0]      blank;
  logic [NUM_LEDS-1:0]      led_on;
  logic [NUM_LEDS-1:0]      leds_reg;
  logic [31:0]              read_word;
  logic [31:0]              read_data_reg;
  logic                     read_data_valid_reg;

  assign prescale_wr = write_req && (addr == LED_ADDR_PRESCALE) && (|byte_enable[1:0]);

  led_pwm_timebase #(
    .PRESCALE_BITS(PRESCALE_BITS),
    .PWM_BITS     (PWM_BITS)
  ) u_timebase (
    .clk       (clk),
    .reset_n   (reset_n),
    .prescale  (prescale_reg),
    .clear     (prescale_wr),
    .pwm       (pwm),
    .period_end(period_end)
  );

  // LEDs 0..3 live in DUTY0, LEDs 4..7 in DUTY1, one byte lane each.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    localparam logic [2:0] LANE_ADDR = (gi < 4) ? LED_ADDR_DUTY0 : LED_ADDR_DUTY1;
    assign duty_we[gi]    = write_req && (addr == LANE_ADDR) && byte_enable[gi % 4];
    assign duty_wdata[gi] = write_data[8*(gi % 4) +: 8];
    assign led_on[gi]     = en_reg[gi] && !blank[gi] &&
                            ((pwm < active_reg[gi]) || (active_reg[gi] == 8'hFF));
  end

  always_comb begin
    prescale_next = 16'(prescale_reg);
    if (byte_enable[0]) prescale_next[7:0]  = write_data[7:0];
    if (byte_enable[1]) prescale_next[15:8] = write_data[15:8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_reg       <= '0;
      prescale_reg <= '0;
      leds_reg     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_reg[i]   <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      if (write_req && (addr == LED_ADDR_CTRL) && byte_enable[0])
        en_reg <= write_data[NUM_LEDS-1:0];
      if (prescale_wr)
        prescale_reg <= prescale_next[PRESCALE_BITS-1:0];
      // Shadow copy uses the pre-write duty, so a boundary-cycle write waits a period.
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (duty_we[i])  duty_reg[i]   <= duty_wdata[i];
        if (period_end)  active_reg[i] <= duty_reg[i];
      end
      leds_reg <= led_on;
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [NUM_LEDS-1:0] blink_mask_reg;
  logic [7:0]          blink_period_reg;
  logic [7:0]          blink_cnt_reg;
  logic                phase_reg;

  assign blank = phase_reg ? blink_mask_reg : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_reg   <= '0;
      blink_period_reg <= '0;
      blink_cnt_reg    <= '0;
      phase_reg        <= 1'b0;
    end else begin
      if (write_req && (addr == LED_ADDR_BLINK)) begin
        if (byte_enable[0])
          blink_mask_reg <= write_data[LED_BLINK_MASK_LSB +: NUM_LEDS];
        if (byte_enable[2])
          blink_period_reg <= write_data[LED_BLINK_PERIOD_MSB:LED_BLINK_PERIOD_LSB];
      end
      // Comparing with >= recovers cleanly if P is lowered below the running count.
      if (period_end) begin
        if (blink_period_reg == 8'd0) begin
          blink_cnt_reg <= '0;
          phase_reg     <= 1'b0;
        end else if (blink_cnt_reg >= blink_period_reg) begin
          blink_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 8'd1;
        end
      end
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    read_word = '0;
    case (addr)
      LED_ADDR_CTRL: read_word[NUM_LEDS-1:0] = en_reg;
      LED_ADDR_DUTY0, LED_ADDR_DUTY1: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if ((i < 4) == (addr == LED_ADDR_DUTY0))
            read_word[8*(i % 4) +: 8] = duty_reg[i];
        end
      end
      LED_ADDR_PRESCALE: read_word[PRESCALE_BITS-1:0] = prescale_reg;
`ifdef LED_PWM_BLINK_EN
      LED_ADDR_BLINK: begin
        read_word[LED_BLINK_MASK_LSB +: NUM_LEDS]               = blink_mask_reg;
        read_word[LED_BLINK_PERIOD_MSB:LED_BLINK_PERIOD_LSB]    = blink_period_reg;
      end
`endif
      default: read_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_reg       <= '0;
      read_data_valid_reg <= 1'b0;
    end else begin
      read_data_reg       <= read_req ? read_word : 32'd0;
      read_data_valid_reg <= read_req;
    end
  end

  assign read_data       = read_data_reg;
  assign read_data_valid = read_data_valid_reg;
  assign leds            = leds_reg;

endmodule
